// File: rtl/img_writer.sv
// Stream-to-memory writer: tracks frame coordinates, buffers pixels in a skid FIFO
// and emits RGB-packed word pairs. Define IMG_WRITER_DROP_CNT_EN to add oDROP_CNT.
module img_writer #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSOF,
  input  logic        iDVAL,
  input  logic [11:0] iPIXEL,
  input  logic        iWR_READY,
  output logic        oWR_VAL,
  output logic [15:0] oWR_DATA1,
  output logic [15:0] oWR_DATA2,
  output logic [10:0] oX,
  output logic [10:0] oY,
  output logic        oFRAME_DONE,
  output logic [7:0]  oFRAME_CNT,
  output logic        oOVERFLOW,
`ifdef IMG_WRITER_DROP_CNT_EN
  output logic [15:0] oDROP_CNT,
`endif
  output logic        oTRUNC
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
  localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [11:0] mem_q [FIFO_DEPTH];
  logic [11:0] mem_d [FIFO_DEPTH];
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        overflow_q, overflow_d;
  logic        trunc_q, trunc_d;
`ifdef IMG_WRITER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  logic        take, pop, push, drop, full, last_px;
  logic [10:0] x_base, y_base;
  logic [11:0] head;

  always_comb begin
    full    = (cnt_q == CNT_FULL);
    pop     = (cnt_q != '0) && iWR_READY;
    take    = iDVAL && ((state_q == S_ACTIVE) || iSOF);
    push    = take && (!full || pop);
    drop    = take && !push;
    // iSOF restarts coordinates before a same-cycle take is counted
    x_base  = iSOF ? '0 : x_q;
    y_base  = iSOF ? '0 : y_q;
    last_px = take && (x_base == X_LAST) && (y_base == Y_LAST);

    x_d = x_base;
    y_d = y_base;
    if (take) begin
      if (x_base == X_LAST) begin
        x_d = '0;
        y_d = (y_base == Y_LAST) ? '0 : y_base + 11'd1;
      end else begin
        x_d = x_base + 11'd1;
      end
    end

    overflow_d = iSOF ? 1'b0 : overflow_q;
    if (drop) overflow_d = 1'b1;
    trunc_d = trunc_q;
    if (iSOF) trunc_d = (state_q == S_ACTIVE) || (state_q == S_FLUSH);

`ifdef IMG_WRITER_DROP_CNT_EN
    drop_cnt_d = iSOF ? '0 : drop_cnt_q;
    if (drop && drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + 16'd1;
`endif

    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_IDLE;
      S_ACTIVE: if (last_px) state_d = S_FLUSH;
      S_FLUSH:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (iSOF) state_d = last_px ? S_FLUSH : S_ACTIVE;

    frame_done_d = (state_q == S_FLUSH) && (state_d == S_DONE);
    frame_cnt_d  = frame_cnt_q + 8'(frame_done_d);

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = iPIXEL;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      mem_q        <= '{default: '0};
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      trunc_q      <= 1'b0;
`ifdef IMG_WRITER_DROP_CNT_EN
      drop_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
      trunc_q      <= trunc_d;
`ifdef IMG_WRITER_DROP_CNT_EN
      drop_cnt_q   <= drop_cnt_d;
`endif
    end
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    oWR_VAL     = (cnt_q != '0);
    oWR_DATA1   = oWR_VAL ? {1'b0, head[11:7], head[11:2]} : '0;
    oWR_DATA2   = oWR_VAL ? {1'b0, head[6:2],  head[11:2]} : '0;
    oX          = x_q;
    oY          = y_q;
    oFRAME_DONE = frame_done_q;
    oFRAME_CNT  = frame_cnt_q;
    oOVERFLOW   = overflow_q;
    oTRUNC      = trunc_q;
`ifdef IMG_WRITER_DROP_CNT_EN
    oDROP_CNT   = drop_cnt_q;
`endif
  end

endmodule

// File: tb/tb_img_writer.sv
// Self-checking bench for img_writer (IMG_W=4, IMG_H=2, FIFO_DEPTH=4): directed
// scenarios plus random traffic against a queue-based reference model.
module tb_img_writer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, sof, dval, rdy;
  logic [11:0] pix;
  logic        wr_val, frame_done, overflow, trunc;
  logic [15:0] d1, d2;
  logic [10:0] ox, oy;
  logic [7:0]  fcnt;
`ifdef IMG_WRITER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  img_writer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
    .iCLK(clk), .iRST(rst), .iSOF(sof), .iDVAL(dval), .iPIXEL(pix),
    .iWR_READY(rdy), .oWR_VAL(wr_val), .oWR_DATA1(d1), .oWR_DATA2(d2),
    .oX(ox), .oY(oy), .oFRAME_DONE(frame_done), .oFRAME_CNT(fcnt),
    .oOVERFLOW(overflow),
`ifdef IMG_WRITER_DROP_CNT_EN
    .oDROP_CNT(drop_cnt),
`endif
    .oTRUNC(trunc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 receiving, 2 draining, 3 done cycle
  int          m_phase, m_pos, m_fcnt, m_drops;
  bit          m_ovf, m_trunc, m_done;
  logic [11:0] m_q[$];

  function automatic logic [15:0] pack1(input int p);
    return 16'(((p / 128) * 1024) + (p / 4));
  endfunction
  function automatic logic [15:0] pack2(input int p);
    return 16'((((p / 4) % 32) * 1024) + (p / 4));
  endfunction

  task automatic model_step();
    int  was;
    bit  mpop, mtake, mlast;
    if (!rst) begin
      m_q.delete(); m_phase = 0; m_pos = 0; m_fcnt = 0; m_drops = 0;
      m_ovf = 0; m_trunc = 0; m_done = 0;
      return;
    end
    was   = m_q.size();
    mpop  = (was > 0) && rdy;
    mtake = dval && (m_phase == 1 || sof);
    m_done = 0;
    if (sof) begin
      m_trunc = (m_phase == 1 || m_phase == 2);
      m_ovf = 0; m_drops = 0; m_pos = 0;
    end
    if (mpop) void'(m_q.pop_front());
    mlast = 0;
    if (mtake) begin
      if (was < D || mpop) m_q.push_back(pix);
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
      mlast = (m_pos == W * H - 1);
      m_pos = (m_pos + 1) % (W * H);
    end
    if (sof) m_phase = mlast ? 2 : 1;
    else case (m_phase)
      1: if (mlast) m_phase = 2;
      2: if (was == 0) begin m_phase = 3; m_done = 1; m_fcnt = (m_fcnt + 1) % 256; end
      3: m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("wr_val", wr_val, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("data1", d1, pack1(m_q[0]));
      chk("data2", d2, pack2(m_q[0]));
    end
    chk("x", ox, m_pos % W);
    chk("y", oy, m_pos / W);
    chk("frame_done", frame_done, m_done);
    chk("frame_cnt", fcnt, m_fcnt);
    chk("overflow", overflow, m_ovf);
    chk("trunc", trunc, m_trunc);
`ifdef IMG_WRITER_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, m_drops);
`endif
    sof = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sof = 1'b0; dval = 1'b0; rdy = 1'b1; pix = '0;
    cycle();
    chk("rst_val", wr_val, 0);
    chk("rst_cnt", fcnt, 0);
    rst = 1'b1;
    cycle();

    // Full frame at full rate
    sof = 1'b1; cycle();
    for (int i = 0; i < 8; i++) begin
      dval = 1'b1; pix = 12'(i); cycle();
      if (i == 4) begin
        chk("px4_d1", d1, 16'h0001);
        chk("px4_d2", d2, 16'h0401);
      end
    end
    dval = 1'b0;
    repeat (6) cycle();
    chk("frame_cnt_1", fcnt, 8'd1);

    // Stall hold
    sof = 1'b1; rdy = 1'b0; cycle();
    dval = 1'b1; pix = 12'hFFF; cycle();
    dval = 1'b0;
    chk("fff_d1", d1, 16'h7FFF);
    chk("fff_d2", d2, 16'h7FFF);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_d1", d1, 16'h7FFF);
      chk("hold_d2", d2, 16'h7FFF);
    end
    rdy = 1'b1; cycle();

    // Overflow: 6 takes into a 4-deep FIFO with no drain
    rdy = 1'b0; sof = 1'b1; cycle();
    for (int i = 0; i < 6; i++) begin
      dval = 1'b1; pix = 12'($urandom); cycle();
    end
    dval = 1'b0;
    chk("ovf_x", ox, 2);
    chk("ovf_y", oy, 1);
    chk("ovf_flag", overflow, 1);
`ifdef IMG_WRITER_DROP_CNT_EN
    chk("ovf_drops", drop_cnt, 2);
`endif

    // Full FIFO with simultaneous push/pop
    sof = 1'b1; cycle();
    chk("ovf_cleared", overflow, 0);
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dval = 1'b1; pix = 12'($urandom); cycle();
    end
    dval = 1'b0;
    chk("pushpop_no_ovf", overflow, 0);
    repeat (6) cycle();

    // Truncated frame
    sof = 1'b1; cycle();
    for (int i = 0; i < 5; i++) begin
      dval = 1'b1; pix = 12'($urandom); cycle();
    end
    dval = 1'b0; sof = 1'b1; cycle();
    chk("trunc_flag", trunc, 1);
    chk("trunc_x", ox, 0);
    chk("trunc_y", oy, 0);
    repeat (6) cycle();

    // Reset with entries queued
    sof = 1'b1; rdy = 1'b0; cycle();
    for (int i = 0; i < 3; i++) begin
      dval = 1'b1; pix = 12'($urandom); cycle();
    end
    dval = 1'b0; rst = 1'b0; cycle();
    chk("rst_mid_val", wr_val, 0);
    chk("rst_mid_cnt", fcnt, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dval = 1'b1; pix = 12'($urandom); cycle();
    end
    chk("idle_ignore_x", ox, 0);
    chk("idle_ignore_val", wr_val, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      sof  = ($urandom_range(0, 39) == 0);
      dval = ($urandom_range(0, 9) < 7);
      rdy  = ($urandom_range(0, 9) < 6);
      pix  = 12'($urandom);
      rst  = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
